// File: rtl/jogo_button_controller.sv
// jogo_button_controller
// Avalon-MM slave for the game board push-buttons. Raw active-low pins are
// synchronised, debounced per bit with a programmable period, and presses
// are latched into a write-1-to-clear EDGE register that drives a maskable
// level interrupt.
//   addr 0 DATA   (RO)   debounced state, 1 = pressed
//   addr 1 MASK   (RW)   irq enable per button
//   addr 2 EDGE   (W1C)  press capture
//   addr 3 RELOAD (RW)   debounce period in cycles (0 acts as 1)
module jogo_button_controller #(
    parameter int WIDTH       = 4,
    parameter int DEB_W       = 20,
    parameter int DEB_DEFAULT = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam logic [1:0]       ADDR_DATA   = 2'd0;
    localparam logic [1:0]       ADDR_MASK   = 2'd1;
    localparam logic [1:0]       ADDR_EDGE   = 2'd2;
    localparam logic [1:0]       ADDR_RELOAD = 2'd3;
    localparam logic [DEB_W-1:0] RELOAD_RST  = DEB_W'(DEB_DEFAULT);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [DEB_W-1:0] r_reload;
    logic [DEB_W-1:0] r_cnt [WIDTH];

    logic             w_wr;
    logic             w_wr_mask;
    logic             w_wr_edge;
    logic             w_wr_reload;
    logic [WIDTH-1:0] w_s;
    logic [DEB_W-1:0] w_lim;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_flip;
    logic [WIDTH-1:0] w_rise;
    logic [DEB_W-1:0] w_cnt_next [WIDTH];
    logic             w_unused;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_mask   = w_wr & (address == ADDR_MASK);
    assign w_wr_edge   = w_wr & (address == ADDR_EDGE);
    assign w_wr_reload = w_wr & (address == ADDR_RELOAD);

    // Synchronised pins in pressed=1 form.
    assign w_s = ~r_sync2;

    // Terminal count is N-1; a programmed 0 is treated like 1 (terminal 0).
    assign w_lim = (r_reload == '0) ? '0 : r_reload - DEB_W'(1);

    assign w_clr = w_wr_edge ? writedata[WIDTH-1:0] : '0;

    // Upper write-data bits beyond the widest register are intentionally ignored.
    assign w_unused = &{1'b0, writedata[31:DEB_W]};

    // Per-button debounce decision. A RELOAD write restarts every count and
    // suppresses any update that would otherwise land in that cycle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
            assign w_flip[gi] = ~w_wr_reload & (w_s[gi] ^ r_stable[gi])
                              & (r_cnt[gi] >= w_lim);
            assign w_cnt_next[gi] = (~w_wr_reload & (w_s[gi] ^ r_stable[gi])
                                     & (r_cnt[gi] < w_lim))
                                  ? r_cnt[gi] + DEB_W'(1) : '0;
        end
    endgenerate

    // Only a stable 0->1 transition (press) is captured; releases are not.
    assign w_rise = w_flip & w_s;

    // Two-flop synchroniser, idling at the released (high) level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // Debounced state and per-button mismatch counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_stable <= r_stable ^ w_flip;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end

    // Control registers; a new press wins over a same-cycle W1C clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask   <= '0;
            r_edge   <= '0;
            r_reload <= RELOAD_RST;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_rise;
            if (w_wr_mask)   r_mask   <= writedata[WIDTH-1:0];
            if (w_wr_reload) r_reload <= writedata[DEB_W-1:0];
        end
    end

    // Registered level interrupt from enabled pending presses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= |(r_edge & r_mask);
    end

    // Registered read mux, zero when not selected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (chipselect) begin
            case (address)
                ADDR_DATA:   readdata <= 32'(r_stable);
                ADDR_MASK:   readdata <= 32'(r_mask);
                ADDR_EDGE:   readdata <= 32'(r_edge);
                ADDR_RELOAD: readdata <= 32'(r_reload);
                default:     readdata <= '0;
            endcase
        end else begin
            readdata <= '0;
        end
    end
endmodule

// File: tb/tb_jogo_button_controller.sv
// Testbench for jogo_button_controller: directed scenarios with fixed
// expected timing plus a randomized run against a sliding-window model.
module tb_jogo_button_controller;
    localparam int HN = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  in_port = 4'hF;
    logic        irq;

    int checks = 0;
    int errors = 0;

    jogo_button_controller #(.WIDTH(4), .DEB_W(20), .DEB_DEFAULT(50000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a button's debounced state flips when the synchronised
    // pin has disagreed with it on each of the last N clock edges, with no
    // RELOAD write, no earlier flip and no reset inside that window.
    int          cyc = 0;
    int          lastrst = 0;
    logic [3:0]  m_stable, m_mask, m_edge;
    logic [19:0] m_reload;
    logic [31:0] m_rdata;
    logic        m_irq;
    logic [3:0]  pin_h  [HN];
    logic        wr_h   [HN];
    logic [3:0]  mm_h   [HN];
    logic [3:0]  flip_h [HN];

    always @(posedge clk) begin : ref_model
        int t, nval, idx;
        logic wr_now, wr_rel, s_i, ok;
        logic [3:0] mmv, flipv, rise, clr;
        t = cyc;
        wr_now = chipselect && !write_n;
        wr_rel = wr_now && (address == 2'd3);
        cyc <= cyc + 1;
        pin_h[t % HN] <= in_port;
        if (!reset_n) begin
            lastrst  <= t;
            m_stable <= 4'h0;
            m_mask   <= 4'h0;
            m_edge   <= 4'h0;
            m_reload <= 20'd50000;
            m_rdata  <= 32'd0;
            m_irq    <= 1'b0;
            wr_h[t % HN]   <= 1'b0;
            mm_h[t % HN]   <= 4'h0;
            flip_h[t % HN] <= 4'h0;
        end else begin
            nval = (m_reload == 20'd0) ? 1 : int'(m_reload);
            for (int i = 0; i < 4; i++) begin
                s_i = (t - 2 > lastrst) ? ~pin_h[(t - 2) % HN][i] : 1'b0;
                mmv[i] = (s_i != m_stable[i]);
                ok = mmv[i] && !wr_rel;
                for (int j = 1; j < nval && ok; j++) begin
                    idx = t - j;
                    if (idx <= lastrst || !mm_h[idx % HN][i] || wr_h[idx % HN] || flip_h[idx % HN][i])
                        ok = 1'b0;
                end
                flipv[i] = ok;
            end
            rise = flipv & ~m_stable;
            clr  = (wr_now && address == 2'd2) ? writedata[3:0] : 4'h0;
            m_stable <= m_stable ^ flipv;
            m_edge   <= (m_edge & ~clr) | rise;
            if (wr_now && address == 2'd1) m_mask <= writedata[3:0];
            if (wr_rel) m_reload <= writedata[19:0];
            m_irq <= |(m_edge & m_mask);
            if (!chipselect)            m_rdata <= 32'd0;
            else if (address == 2'd0)   m_rdata <= {28'd0, m_stable};
            else if (address == 2'd1)   m_rdata <= {28'd0, m_mask};
            else if (address == 2'd2)   m_rdata <= {28'd0, m_edge};
            else                        m_rdata <= {12'd0, m_reload};
            wr_h[t % HN]   <= wr_rel;
            mm_h[t % HN]   <= mmv;
            flip_h[t % HN] <= flipv;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        d = readdata;
        $display("read  addr=%0d data=0x%08h", a, d);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n = 1'b0; in_port = 4'hF;
        cycles(3);
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset_n = 1'b1;
        cycles(1);
        bus_read(2'd3, d);
        checks++; if (d !== 32'd50000) begin errors++; $display("FAIL reset_reload got=%0d exp=50000", d); end
        for (int a = 0; a < 3; a++) begin
            bus_read(2'(a), d);
            checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
        end
    endtask

    task automatic test_clean_press;
        logic [31:0] d;
        bus_write(2'd3, 32'd4);
        bus_write(2'd1, 32'h1);
        in_port[0] = 1'b0;
        address = 2'd0; chipselect = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            checks++; if (readdata !== ((k >= 7) ? 32'h1 : 32'h0)) begin errors++; $display("FAIL press_data k=%0d got=%h exp=%h", k, readdata, (k >= 7) ? 1 : 0); end
            checks++; if (irq !== (k >= 7)) begin errors++; $display("FAIL press_irq k=%0d got=%b exp=%b", k, irq, k >= 7); end
            checks++; if (readdata !== m_rdata) begin errors++; $display("FAIL press_model_data k=%0d got=%h exp=%h", k, readdata, m_rdata); end
        end
        chipselect = 1'b0;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL press_edge got=%h exp=1", d); end
        in_port = 4'hF;
        cycles(8);
        bus_write(2'd2, 32'hF);
        cycles(2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL press_irq_clear got=%b exp=0", irq); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL press_release_data got=%h exp=0", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL press_release_edge got=%h exp=0", d); end
    endtask

    task automatic test_bounce;
        logic [31:0] d;
        bus_write(2'd3, 32'd4);
        bus_write(2'd1, 32'h2);
        repeat (5) begin
            in_port[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                cycles(1);
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL bounce_irq got=%b exp=0", irq); end
            end
            in_port[1] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                cycles(1);
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL bounce_irq got=%b exp=0", irq); end
            end
        end
        cycles(4);
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL bounce_data got=%h exp=0", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL bounce_edge got=%h exp=0", d); end
    endtask

    task automatic test_w1c_mask;
        logic [31:0] d;
        bus_write(2'd3, 32'd2);
        in_port = 4'hC;
        cycles(8);
        bus_write(2'd1, 32'h2);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL w1c_edge_init got=%h exp=3", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_init got=%b exp=1", irq); end
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_edge_bit0 got=%h exp=2", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_hold got=%b exp=1", irq); end
        bus_write(2'd2, 32'h2);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_latency got=%b exp=1", irq); end
        cycles(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop got=%b exp=0", irq); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_edge_clear got=%h exp=0", d); end
        in_port = 4'hF;
        cycles(8);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_release_edge got=%h exp=0", d); end
    endtask

    task automatic test_set_wins;
        logic [31:0] d;
        bus_write(2'd3, 32'd3);
        bus_write(2'd1, 32'h4);
        in_port[2] = 1'b0;
        cycles(4);
        bus_write(2'd2, 32'h4);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL setwins_edge got=%h exp=4", d); end
        checks++; if (d !== m_rdata) begin errors++; $display("FAIL setwins_model got=%h exp=%h", d, m_rdata); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL setwins_irq got=%b exp=1", irq); end
        bus_write(2'd2, 32'h4);
        cycles(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL setwins_irq_clear got=%b exp=0", irq); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL setwins_edge_clear got=%h exp=0", d); end
        in_port = 4'hF;
        cycles(8);
    endtask

    task automatic test_release_reload;
        logic [31:0] d;
        bus_write(2'd3, 32'd4);
        in_port[3] = 1'b0;
        cycles(8);
        bus_write(2'd2, 32'hF);
        bus_write(2'd1, 32'h8);
        in_port[3] = 1'b1;
        cycles(1);
        in_port[3] = 1'b0;
        cycles(1);
        in_port[3] = 1'b1;
        bus_write(2'd3, 32'd10);
        address = 2'd0; chipselect = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            checks++; if (readdata[3] !== (k < 12)) begin errors++; $display("FAIL reload_data3 k=%0d got=%b exp=%b", k, readdata[3], k < 12); end
            checks++; if (readdata !== m_rdata) begin errors++; $display("FAIL reload_model k=%0d got=%h exp=%h", k, readdata, m_rdata); end
        end
        chipselect = 1'b0;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reload_edge got=%h exp=0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reload_irq got=%b exp=0", irq); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd10) begin errors++; $display("FAIL reload_value got=%0d exp=10", d); end
    endtask

    task automatic test_random;
        int r, b, op;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                b = $urandom_range(0, 3);
                in_port[b] = ~in_port[b];
            end
            op = $urandom_range(0, 9);
            chipselect = 1'b0; write_n = 1'b1;
            address = 2'($urandom_range(0, 3));
            if (op < 4) begin
                chipselect = 1'b1;
            end else if (op < 6) begin
                chipselect = 1'b1; write_n = 1'b0;
                writedata = (address == 2'd3) ? 32'($urandom_range(0, 5)) : $urandom;
            end
            @(posedge clk);
            #1;
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL random_irq n=%0d got=%b exp=%b", n, irq, m_irq); end
            checks++; if (readdata !== m_rdata) begin errors++; $display("FAIL random_readdata n=%0d got=%h exp=%h", n, readdata, m_rdata); end
        end
        chipselect = 1'b0; write_n = 1'b1;
        in_port = 4'hF;
        cycles(12);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        bus_write(2'd3, 32'd4);
        bus_write(2'd1, 32'hF);
        in_port = 4'h0;
        cycles(10);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rstmid_irq_pre got=%b exp=1", irq); end
        in_port = 4'hE;
        cycles(3);
        reset_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq_async got=%b exp=0", irq); end
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_edge got=%h exp=0", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_mask got=%h exp=0", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd50000) begin errors++; $display("FAIL rstmid_reload got=%0d exp=50000", d); end
        in_port = 4'hF;
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_w1c_mask;
        test_set_wins;
        test_release_reload;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jogo_button_controller.md
# jogo_button_controller

Debounce, edge-detect and interrupt controller for the game board's 4 push-buttons, replacing the bare input port on the Avalon-MM bus. Raw active-low button pins are synchronised, filtered with a software-programmable debounce period, and latched into a write-1-to-clear edge-capture register. A maskable interrupt lets the Nios II game loop react to presses without polling.

## Interface
- WIDTH, 4: number of buttons.
- DEB_W, 20: debounce counter / reload register width.
- DEB_DEFAULT, 50000: reset value of debounce reload (1 ms at 50 MHz).

- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select (word address).
- chipselect  in  1  slave select; qualifies write_n.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw button pins, active-low (0 = pressed), asynchronous.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map (unused bits read 0, writes ignored):
  - 0 DATA (RO): bit i = debounced state of button i, 1 = pressed.
  - 1 MASK (RW): bit i enables irq contribution of EDGE[i]. Reset 0.
  - 2 EDGE (R/W1C): bit i set on debounced press (0->1 of DATA[i]); writing 1 clears, writing 0 leaves it. Reset 0.
  - 3 RELOAD (RW, DEB_W bits): debounce period N in cycles. Reset DEB_DEFAULT. Value 0 behaves as 1.
- Synchroniser: two flops per bit on in_port, reset to all-ones (released); output inverted to pressed=1 form (s).
- Per-bit debounce, independent counters cnt[i] (DEB_W bits, reset 0), stable[i] reset 0:
  - s[i] == stable[i]: cnt[i] <= 0.
  - s[i] != stable[i] and cnt[i] < N-1: cnt[i] <= cnt[i]+1.
  - s[i] != stable[i] and cnt[i] >= N-1: stable[i] <= s[i], cnt[i] <= 0.
  - Any glitch shorter than N consecutive cycles never reaches stable; mismatch interruption restarts count from 0.
- Edge capture: EDGE[i] <= (EDGE[i] & ~clr[i]) | rise[i]; rise = stable transition 0->1. Simultaneous set and W1C clear on same bit in same cycle: set wins. Releases (1->0) never set EDGE.
- Write to RELOAD: new N used from next cycle; all cnt cleared to 0 in the write cycle; stable unchanged.
- irq <= |(EDGE & MASK), registered.
- Read: readdata <= selected register when chipselect=1, else 0; value zero-extended to 32 bits. Reads have no side effects.

## Timing
- Reset values: readdata 0, irq 0, DATA 0, MASK 0, EDGE 0, RELOAD DEB_DEFAULT, all cnt 0, sync flops 1.
- Reset is asynchronous assert; reset mid-debounce discards partial counts and pending edges.
- Pin to s: 2 cycles. s change to stable update: N cycles of continuous mismatch. EDGE set on same edge as stable update; irq asserts 1 cycle later. Total pin-to-irq: N+3 cycles.
- readdata valid 1 cycle after address/chipselect (read latency 1). Write takes effect on the clock edge where chipselect=1 and write_n=0; read in the following cycle returns the new value.
- irq deasserts 1 cycle after the W1C write that clears the last enabled pending bit, or after MASK write that disables it.

## Test plan
- Reset: hold reset_n=0, in_port=4'hF -> readdata=0, irq=0; read reg3 after release returns 50000.
- Clean press: write RELOAD=4, MASK=4'h1; drive in_port[0]=0 -> DATA reads 4'h1 and EDGE reads 4'h1 exactly 6 cycles after the pin change, irq=1 at cycle 7.
- Bounce reject: RELOAD=4, toggle in_port[1] low for 3 cycles then high, repeated 5 times -> DATA[1] and EDGE[1] stay 0, irq stays 0.
- W1C and masking: EDGE=4'h3, MASK=4'h2; write reg2=4'h1 -> EDGE=4'h2, irq stays 1; write reg2=4'h2 -> EDGE=0, irq=0 one cycle later.
- Set-wins collision: schedule W1C of bit 2 on the same cycle button 2 debounces to pressed -> EDGE[2]=1 after the cycle.
- Release and RELOAD update: hold button 3 pressed, write RELOAD=10 mid-release bounce -> count restarts, DATA[3] drops to 0 after 12 cycles from the write with release stable, EDGE[3] not set.
